// File: rtl/fb_pkg.sv
// Shared constants and helpers for the filter-bank write and address units.
package fb_pkg;

    localparam int unsigned FB_DATA_W     = 16;
    localparam int unsigned FB_FRAME_LOG2 = 11;

    typedef logic bank_t;

    typedef enum logic {
        FILL  = 1'b0,
        STALL = 1'b1
    } wr_state_e;

    // Reverses the low n bits of v; the upper bits of the result are zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned n);
        logic [31:0] r;
        logic [31:0] t;
        r = '0;
        t = v;
        for (int unsigned i = 0; i < n; i++) begin
            r = {r[30:0], t[0]};
            t = t >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fb_bitrev.sv
// Combinational bit reversal of a frame index.
module fb_bitrev
    import fb_pkg::*;
#(
    parameter int unsigned W = FB_FRAME_LOG2
) (
    input  logic [W-1:0] i_idx,
    output logic [W-1:0] o_rev
);

    logic [31:0] w_rev_full;

    always_comb begin
        w_rev_full = bitrev(32'(i_idx), W);
        o_rev      = w_rev_full[W-1:0];
    end

endmodule

// File: rtl/fb_frame_writer.sv
// Ping-pong frame writer: streams samples into alternating BRAM banks and
// hands each completed bank to the reader.
module fb_frame_writer
    import fb_pkg::*;
#(
    parameter int unsigned DATA_W     = FB_DATA_W,
    parameter int unsigned FRAME_LOG2 = FB_FRAME_LOG2,
    parameter int unsigned BITREV     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  in_ready,
    input  logic                  rd_release,
    output logic                  we,
    output logic [FRAME_LOG2:0]   waddr,
    output logic [DATA_W-1:0]     wdata,
    output logic                  switch,
    output logic                  frame_done,
    output logic                  err_release
);

    logic [FRAME_LOG2-1:0] r_idx;
    bank_t                 r_wb;
    bank_t                 r_rb;
    logic [1:0]            r_full;
    logic                  r_we;
    logic [FRAME_LOG2:0]   r_waddr;
    logic [DATA_W-1:0]     r_wdata;
    bank_t                 r_switch;
    logic                  r_frame_done;
    logic                  r_err;

    logic [FRAME_LOG2-1:0] w_idx_rev;
    logic [FRAME_LOG2-1:0] w_idx_wr;
    logic [1:0]            w_full_nxt;
    wr_state_e             w_state;
    logic                  w_accept;
    logic                  w_complete;
    logic                  w_rel_ok;
    logic                  w_rel_bad;

    fb_bitrev #(.W(FRAME_LOG2)) u_bitrev (
        .i_idx (r_idx),
        .o_rev (w_idx_rev)
    );

    assign w_idx_wr = (BITREV != 0) ? w_idx_rev : r_idx;

    // FILL/STALL is derived from the full flag of the bank being written.
    always_comb begin
        w_state    = r_full[r_wb] ? STALL : FILL;
        in_ready   = (w_state == FILL);
        w_accept   = in_valid && in_ready;
        w_complete = w_accept && (r_idx == '1);
        w_rel_ok   = rd_release && r_full[r_rb];
        w_rel_bad  = rd_release && !r_full[r_rb];
        w_full_nxt = r_full;
        if (w_rel_ok) begin
            w_full_nxt[r_rb] = 1'b0;
        end
        // The filling bank is never full, so this never collides with the release.
        if (w_complete) begin
            w_full_nxt[r_wb] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx        <= '0;
            r_wb         <= 1'b0;
            r_rb         <= 1'b0;
            r_full       <= '0;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_switch     <= 1'b0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_we         <= w_accept;
            r_frame_done <= w_complete;
            r_full       <= w_full_nxt;
            if (w_accept) begin
                r_waddr <= {r_wb, w_idx_wr};
                r_wdata <= in_data;
                r_idx   <= r_idx + 1'b1;
            end
            if (w_complete) begin
                r_switch <= r_wb;
                r_wb     <= ~r_wb;
            end
            if (w_rel_ok) begin
                r_rb <= ~r_rb;
            end
            if (w_rel_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    assign we          = r_we;
    assign waddr       = r_waddr;
    assign wdata       = r_wdata;
    assign switch      = r_switch;
    assign frame_done  = r_frame_done;
    assign err_release = r_err;

endmodule

// File: tb/tb_fb_frame_writer.sv
// Randomized and directed bench for fb_frame_writer, natural and bit-reversed.
module tb_fb_frame_writer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        rd_release;

    logic        rdy0, we0, sw0, fd0, err0;
    logic [3:0]  wa0;
    logic [15:0] wd0;
    logic        rdy1, we1, sw1, fd1, err1;
    logic [3:0]  wa1;
    logic [15:0] wd1;

    fb_frame_writer #(.DATA_W(16), .FRAME_LOG2(3), .BITREV(0)) u_nat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy0), .rd_release(rd_release), .we(we0), .waddr(wa0),
        .wdata(wd0), .switch(sw0), .frame_done(fd0), .err_release(err0)
    );

    fb_frame_writer #(.DATA_W(16), .FRAME_LOG2(3), .BITREV(1)) u_rev (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy1), .rd_release(rd_release), .we(we1), .waddr(wa1),
        .wdata(wd1), .switch(sw1), .frame_done(fd1), .err_release(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: total samples accepted since reset plus a FIFO of
    // completed banks waiting for the reader.
    int acc;
    int pending[$];
    bit m_we, m_fd, m_sw, m_err;
    int m_wa0, m_wa1, m_wd;

    function automatic int rev3(input int x);
        return ((x & 1) << 2) | (x & 2) | ((x >> 2) & 1);
    endfunction

    function automatic int cur_bank();
        return (acc / 8) % 2;
    endfunction

    function automatic bit model_ready();
        foreach (pending[i]) if (pending[i] == cur_bank()) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge(input bit v, input int d, input bit rel, input bit r);
        bit acc_ok;
        int idx;
        int b;
        if (r) begin
            acc = 0;
            pending.delete();
            m_we = 0; m_fd = 0; m_sw = 0; m_err = 0;
            m_wa0 = 0; m_wa1 = 0; m_wd = 0;
            return;
        end
        acc_ok = v && model_ready();
        b = cur_bank();
        idx = acc % 8;
        if (rel) begin
            if (pending.size() > 0) void'(pending.pop_front());
            else m_err = 1;
        end
        m_we = acc_ok;
        m_fd = 0;
        if (acc_ok) begin
            m_wa0 = b * 8 + idx;
            m_wa1 = b * 8 + rev3(idx);
            m_wd  = d;
            if (idx == 7) begin
                m_fd = 1;
                m_sw = b[0];
                pending.push_back(b);
            end
            acc++;
        end
    endtask

    task automatic step(input bit v, input logic [15:0] d, input bit rel, input bit r);
        in_valid = v; in_data = d; rd_release = rel; rst = r;
        @(negedge clk);
        if (!r) begin
            chk("in_ready_nat", 32'(rdy0), 32'(model_ready()));
            chk("in_ready_rev", 32'(rdy1), 32'(model_ready()));
        end
        @(posedge clk);
        #1;
        model_edge(v, 32'(d), rel, r);
        chk("we_nat", 32'(we0), 32'(m_we));
        chk("we_rev", 32'(we1), 32'(m_we));
        chk("frame_done_nat", 32'(fd0), 32'(m_fd));
        chk("frame_done_rev", 32'(fd1), 32'(m_fd));
        chk("switch_nat", 32'(sw0), 32'(m_sw));
        chk("switch_rev", 32'(sw1), 32'(m_sw));
        chk("err_nat", 32'(err0), 32'(m_err));
        chk("err_rev", 32'(err1), 32'(m_err));
        if (m_we || r) begin
            chk("waddr_nat", 32'(wa0), 32'(m_wa0));
            chk("waddr_rev", 32'(wa1), 32'(m_wa1));
            chk("wdata_nat", 32'(wd0), 32'(m_wd));
            chk("wdata_rev", 32'(wd1), 32'(m_wd));
        end
    endtask

    task automatic do_reset();
        step(1'b0, 16'h0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b1);
    endtask

    int rev_seq[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    initial begin
        in_valid = 0; in_data = 0; rd_release = 0; rst = 1;
        acc = 0;
        @(posedge clk);
        #1;

        // Single frame, natural and bit-reversed side by side.
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 16'(i), 1'b0, 1'b0);
            chk("s1_waddr_nat", 32'(wa0), 32'(i - 1));
            chk("s1_waddr_rev", 32'(wa1), 32'(rev_seq[i-1]));
            chk("s1_wdata", 32'(wd1), 32'(i));
            chk("s1_frame_done", 32'(fd0), (i == 8) ? 32'd1 : 32'd0);
        end
        chk("s1_switch", 32'(sw0), 32'd0);
        step(1'b1, 16'h0009, 1'b0, 1'b0);
        chk("s1_next_waddr", 32'(wa0), 32'd8);

        // Fill both banks, hold the 17th sample, then release.
        do_reset();
        for (int i = 1; i <= 16; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'h0011, 1'b0, 1'b0);
            chk("s3_held_we", 32'(we0), 32'd0);
        end
        chk("s3_stalled", 32'(rdy0), 32'd0);
        step(1'b1, 16'h0011, 1'b1, 1'b0);
        chk("s3_ready_after_rel", 32'(rdy0), 32'd1);
        step(1'b1, 16'h0011, 1'b0, 1'b0);
        chk("s3_resume_we", 32'(we0), 32'd1);
        chk("s3_resume_waddr", 32'(wa0), 32'd0);
        chk("s3_resume_wdata", 32'(wd0), 32'h0011);

        // Release coinciding with the 16th accept.
        do_reset();
        for (int i = 1; i <= 15; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        step(1'b1, 16'h0010, 1'b1, 1'b0);
        chk("s4_switch", 32'(sw0), 32'd1);
        chk("s4_ready", 32'(rdy0), 32'd1);
        step(1'b1, 16'h0020, 1'b0, 1'b0);
        chk("s4_next_waddr", 32'(wa0), 32'd0);

        // Release with no full bank.
        do_reset();
        step(1'b0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
        chk("s5_err_sticky", 32'(err0), 32'd1);
        step(1'b1, 16'h00AA, 1'b0, 1'b0);
        chk("s5_waddr", 32'(wa0), 32'd0);
        do_reset();
        chk("s5_err_cleared", 32'(err0), 32'd0);

        // Reset in the middle of a frame.
        for (int i = 1; i <= 5; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        do_reset();
        step(1'b1, 16'h0055, 1'b0, 1'b0);
        chk("s6_waddr", 32'(wa0), 32'd0);
        chk("s6_no_done", 32'(fd0), 32'd0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 7, 16'($urandom),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 399) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fb_frame_writer.md
Name: fb_frame_writer

Overview:
- Write-side counterpart to the filter-bank address unit, which generates read addresses and bank selects.
- Accepts a stream of processed ECG samples.
- Writes each frame into one half of a ping-pong dual-port BRAM: natural or bit-reversed order.
- Hands completed banks to the reader via a `switch` bank-select and a frame_done pulse. Applies backpressure while both banks await release.

Parameters:
DATA_W, 16, sample width in bits
FRAME_LOG2, 11, log2 of samples per frame; write address width = FRAME_LOG2+1, where the MSB is the bank bit
BITREV, 0, 1 = write the in-frame index in bit-reversed order; 0 = natural order

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  input sample present
in_data  in  DATA_W  input sample
in_ready  out  1  block can accept a sample this cycle
rd_release  in  1  one-cycle pulse: the reader has finished the oldest full bank
we  out  1  BRAM write enable
waddr  out  FRAME_LOG2+1  BRAM write address {bank, index}
wdata  out  DATA_W  BRAM write data
switch  out  1  bank the reader must use (last completed bank)
frame_done  out  1  one-cycle pulse when a bank becomes full
err_release  out  1  sticky: rd_release arrived with no full bank

Behaviour:
- Reset values (rst high at a clock edge):
  - Outputs: we=0, waddr=0, wdata=0, switch=0, frame_done=0, err_release=0.
  - Internal: idx=0, wb=0, rb=0, full=2'b00.
  - in_ready=1 in the first cycle after reset.
- Reset mid-frame discards the partial frame and all full flags. No frame_done is produced.
- Handshake:
  - A sample is accepted on a clock edge where in_valid && in_ready.
  - in_ready = !full[wb], computed combinationally from registered state.
- Write timing (latency 1): for a sample accepted at edge n, from edge n until edge n+1:
  - we=1
  - waddr={wb, BITREV ? bitrev(idx) : idx}
  - wdata=in_data
  - we=0 in all other cycles.
- Index handling: idx increments per accepted sample and wraps from 2^FRAME_LOG2-1 to 0.
- Frame completion: acceptance at idx=2^FRAME_LOG2-1 completes the frame. On that edge:
  - full[wb] is set.
  - switch is set to the old wb.
  - wb toggles.
  - frame_done=1 for exactly one cycle, concurrent with the last write.
- Release:
  - rd_release with full[rb]=1 clears full[rb] and toggles rb.
  - rd_release with full[rb]=0 is ignored, except that err_release is set (cleared only by rst).
- Simultaneous completion and release on the same edge:
  - Both take effect.
  - If they target different banks, both flags update.
  - The same bank cannot be targeted (a filling bank is never full).
- States: FILL (full[wb]=0) and STALL (full[wb]=1). Implement as derived state, not a separate encoding.
  - FILL→STALL on completion when full[~wb] was already 1 and is not released on that edge.
  - STALL→FILL on the edge rd_release clears full[wb].
- The first sample after a stall is written at idx=0 of the freed bank. No samples are lost or duplicated.
- in_valid while in STALL: the sample is held by upstream (not accepted); no write occurs.

Decomposition:
- Shared package fb_pkg: DATA_W and FRAME_LOG2 defaults, a bit-reverse function, and the bank-index typedef. The address unit uses the same constants.
- Sub-module fb_bitrev (combinational, FRAME_LOG2-wide reversal). Everything else stays in one module.

Test Plan:
All scenarios use FRAME_LOG2=3, DATA_W=16.
- Reset, then 8 continuous valid samples 0x0001..0x0008 with BITREV=0:
  - waddr 0..7 with bank 0.
  - frame_done pulses with the 8th write.
  - switch=0; next write goes to waddr=8.
- Same stimulus with BITREV=1:
  - waddr sequence 0,4,2,6,1,5,3,7.
  - wdata 0x0001..0x0008 in acceptance order.
- 16 samples without any release:
  - Both banks fill; in_ready=0 after the 16th accept.
  - 17th sample held; no we.
  - A rd_release pulse → in_ready=1 the next cycle; 17th sample written at waddr=0 (bank 0).
- rd_release on the same edge as the 16th accept:
  - Bank 0 freed, bank 1 full; in_ready stays 1.
  - switch=1.
- rd_release right after reset → err_release=1, persists until rst. No other state change.
- rst asserted after 5 samples of frame 0:
  - All outputs return to reset values.
  - The next accepted sample is written at waddr=0 with no prior frame_done.
